imem_responder: RTL and testbench

- Responder end of the instruction-memory bus that the fetch stage drives.
- Takes the fetch address and returns the instruction word in the same cycle on a hit.
- Backed by a direct-mapped instruction line buffer. On a miss, refills the line from a slower backing memory using a req/ack handshake, and holds stall high so the PC register enable is deasserted.
- Sits between the fetch datapath and the board-level memory.

---
 rtl/imem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_imem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Responder end of the instruction-memory bus driven by the fetch stage.
//   A direct-mapped line buffer returns the instruction word in the same cycle
//   on a hit. On a miss the whole line is refilled from a slower backing memory
//   over a req/ack handshake, and stall is held high until the line is usable.
//
//   Optional feature macro: IMEM_RESPONDER_STATS_EN
//     defined   -> saturating hit/miss counters on hit_count / miss_count
//     undefined -> no counter flops, both outputs tied to zero
//
// Ports
//   clk         clock
//   reset       asynchronous, active-high reset
//   addr        fetch address (byte address, bits [1:0] ignored)
//   data        instruction word, zero when not hitting
//   stall       high while data is not valid (fetch holds PC)
//   flush       invalidate all lines
//   mem_req     backing read request, held high for the whole refill
//   mem_addr    backing byte address of the word being requested
//   mem_ack     backing read data valid this cycle
//   mem_rdata   backing read data
//   hit_count   hit statistics (zero when stats are disabled)
//   miss_count  miss statistics (zero when stats are disabled)
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic              stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;
  localparam int SEL_W = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Control state (reset)
  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_miss_tag;
  logic [IDX_W-1:0]   r_miss_idx;
  logic [OFF_W-1:0]   r_word_cnt;
  logic               r_flush_pending;
  logic               r_mem_req;
  logic [ADDR_W-1:0]  r_mem_addr;

  // Storage arrays (never reset; guarded by r_valid)
  logic [TAG_W-1:0]   r_tag_ram  [LINES];
  logic [31:0]        r_data_ram [LINES*WORDS_PER_LINE];

  // Address decomposition
  logic [OFF_W-1:0]   w_offset;
  logic [IDX_W-1:0]   w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [SEL_W-1:0]   w_rd_sel;
  logic [SEL_W-1:0]   w_wr_sel;
  logic               w_hit;
  logic               w_miss_start;
  logic               w_unused_addr;

  assign w_offset      = addr[2 +: OFF_W];
  assign w_index       = addr[2 + OFF_W +: IDX_W];
  assign w_tag         = addr[ADDR_W-1 -: TAG_W];
  assign w_rd_sel      = {w_index, w_offset};
  assign w_wr_sel      = {r_miss_idx, r_word_cnt};
  assign w_unused_addr = &{1'b0, addr[1:0]};

  // Hit detect: only IDLE can hit, so stall covers REFILL and DONE as well
  always_comb begin
    w_hit = 1'b0;
    if ((r_state == ST_IDLE) && r_valid[w_index] && (r_tag_ram[w_index] == w_tag)) begin
      w_hit = 1'b1;
    end else begin
      w_hit = 1'b0;
    end
  end

  // A flush in IDLE takes priority over starting a refill in the same cycle
  assign w_miss_start = (r_state == ST_IDLE) && !w_hit && !flush;

  assign data     = w_hit ? r_data_ram[w_rd_sel] : 32'h0;
  assign stall    = ~w_hit;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  // Refill controller: valid bits, handshake and word sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_valid         <= '0;
      r_miss_tag      <= '0;
      r_miss_idx      <= '0;
      r_word_cnt      <= '0;
      r_flush_pending <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (!w_hit) begin
            // Line is invalidated now so a partially refilled line never hits
            r_miss_tag         <= w_tag;
            r_miss_idx         <= w_index;
            r_valid[w_index]   <= 1'b0;
            r_word_cnt         <= '0;
            r_mem_req          <= 1'b1;
            r_mem_addr         <= {w_tag, w_index, {OFF_W{1'b0}}, 2'b00};
            r_state            <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (flush) begin
            r_flush_pending <= 1'b1;
          end
          if (mem_ack) begin
            // Counter wraps back to zero exactly on the last word
            r_word_cnt <= r_word_cnt + OFF_W'(1);
            if (r_word_cnt == LAST_WORD) begin
              r_mem_req <= 1'b0;
              r_state   <= ST_DONE;
            end else begin
              r_mem_addr <= {r_miss_tag, r_miss_idx, r_word_cnt + OFF_W'(1), 2'b00};
            end
          end
        end
        ST_DONE: begin
          // A flush seen at any point during the refill discards every line
          if (r_flush_pending || flush) begin
            r_valid <= '0;
          end else begin
            r_valid[r_miss_idx] <= 1'b1;
          end
          r_flush_pending <= 1'b0;
          r_state         <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Tag array: written when a refill starts
  always_ff @(posedge clk) begin
    if (w_miss_start) begin
      r_tag_ram[w_index] <= w_tag;
    end
  end

  // Data array: each acknowledged word lands at the current word slot
  always_ff @(posedge clk) begin
    if ((r_state == ST_REFILL) && mem_ack) begin
      r_data_ram[w_wr_sel] <= mem_rdata;
    end
  end

`ifdef IMEM_RESPONDER_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating statistics counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (w_hit && !stall && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_start && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Directed, self-checking bench for imem_responder (default parameters:
//   16 lines x 4 words, so index = addr[7:4], tag = addr[31:8]).
//   The backing memory returns the word's own byte address as its data, so the
//   expected instruction word for any fetch address is that address with
//   bits [1:0] cleared.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] data;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks;
  int n_fail;

  imem_responder #(
    .LINES          (16),
    .WORDS_PER_LINE (4),
    .ADDR_W         (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data       (data),
    .stall      (stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a full refill of the line holding a, starting in the miss cycle.
  // period = cycles per word; the ack comes on the last cycle of each word.
  task automatic run_refill(input logic [31:0] a, input int period, input string nm);
    logic [31:0] base;
    logic [31:0] wa;
    base    = {a[31:4], 4'h0};
    addr    = a;
    mem_ack = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_miss_stall: got %b want 1", nm, stall); end
    for (int w = 0; w < 4; w++) begin
      wa = base + 32'(4 * w);
      for (int k = 0; k < period; k++) begin
        @(posedge clk); #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s_req w%0d k%0d: got %b want 1", nm, w, k, mem_req); end
        n_checks++; if (mem_addr !== wa) begin n_fail++; $display("FAIL %s_addr w%0d k%0d: got %h want %h", nm, w, k, mem_addr, wa); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall w%0d: got %b want 1", nm, w, stall); end
        mem_ack   = (k == period - 1);
        mem_rdata = wa;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s_done_req: got %b want 0", nm, mem_req); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_done_stall: got %b want 1", nm, stall); end
    @(posedge clk); #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s_hit_stall: got %b want 0", nm, stall); end
    n_checks++; if (data !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_hit_data: got %h want %h", nm, data, {a[31:2], 2'b00}); end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    addr      = 32'h0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", stall); end
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
    n_checks++; if (hit_count !== 32'h0) begin n_fail++; $display("FAIL reset_hit_count: got %h want 0", hit_count); end
    n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count: got %h want 0", miss_count); end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    run_refill(32'h0000_0104, 1, "cold");
  endtask

  task automatic test_same_line_hit;
    addr    = 32'h0000_010C;
    mem_ack = 1'b1;   // stray ack outside REFILL must be ignored
    #1;
    n_checks++; if (data !== 32'h0000_010C) begin n_fail++; $display("FAIL hit10c_data: got %h want 0000010c", data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hit10c_stall: got %b want 0", stall); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit10c_req: got %b want 0", mem_req); end
    addr = 32'h0000_0100;
    #1;
    n_checks++; if (data !== 32'h0000_0100) begin n_fail++; $display("FAIL hit100_data: got %h want 00000100", data); end
    addr = 32'h0000_010B;   // low bits ignored
    #1;
    n_checks++; if (data !== 32'h0000_0108) begin n_fail++; $display("FAIL hit10b_data: got %h want 00000108", data); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_next_req: got %b want 0", mem_req); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hit_next_stall: got %b want 0", stall); end
  endtask

  task automatic test_conflict;
    run_refill(32'h0000_1104, 1, "evict");
    addr = 32'h0000_0108;   // old tag, same index: must be gone
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL evicted_stall: got %b want 1", stall); end
    run_refill(32'h0000_0104, 1, "refetch");
`ifdef IMEM_RESPONDER_STATS_EN
    n_checks++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
    n_checks++; if (hit_count === 32'd0) begin n_fail++; $display("FAIL conflict_hit_count: got 0 want nonzero"); end
`else
    n_checks++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL conflict_miss_count: got %0d want 0", miss_count); end
    n_checks++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL conflict_hit_count: got %0d want 0", hit_count); end
`endif
  endtask

  task automatic test_wait_states;
    run_refill(32'h0000_0454, 3, "wait");
    addr = 32'h0000_0450; #1;
    n_checks++; if (data !== 32'h0000_0450) begin n_fail++; $display("FAIL wait_w0: got %h want 00000450", data); end
    addr = 32'h0000_0458; #1;
    n_checks++; if (data !== 32'h0000_0458) begin n_fail++; $display("FAIL wait_w2: got %h want 00000458", data); end
    addr = 32'h0000_045C; #1;
    n_checks++; if (data !== 32'h0000_045C) begin n_fail++; $display("FAIL wait_w3: got %h want 0000045c", data); end
  endtask

  task automatic test_flush;
    logic [31:0] wa;
    // Flush in IDLE with a missing address: no refill starts, all lines cleared
    @(posedge clk); #1;
    addr  = 32'h0000_0234;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_flush_req: got %b want 0", mem_req); end
    addr = 32'h0000_0454; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL idle_flush_clear: got %b want 1", stall); end
    // Flush during word 2 of a refill
    addr = 32'h0000_0234; #1;
    for (int w = 0; w < 4; w++) begin
      wa = 32'h0000_0230 + 32'(4 * w);
      @(posedge clk); #1;
      n_checks++; if (mem_addr !== wa) begin n_fail++; $display("FAIL fl_addr w%0d: got %h want %h", w, mem_addr, wa); end
      mem_ack   = 1'b1;
      mem_rdata = wa;
      flush     = (w == 2);
    end
    @(posedge clk); #1;
    flush   = 1'b0;
    mem_ack = 1'b0;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fl_done_req: got %b want 0", mem_req); end
    @(posedge clk); #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fl_line_invalid: got %b want 1", stall); end
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL fl_data: got %h want 0", data); end
    run_refill(32'h0000_0234, 1, "fl_refetch");
  endtask

  task automatic test_reset_mid_refill;
    addr    = 32'h0000_0348;
    mem_ack = 1'b0;
    #1;
    @(posedge clk); #1;
    n_checks++; if (mem_addr !== 32'h0000_0340) begin n_fail++; $display("FAIL rst_w0_addr: got %h want 00000340", mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0340;
    @(posedge clk); #1;
    n_checks++; if (mem_addr !== 32'h0000_0344) begin n_fail++; $display("FAIL rst_w1_addr: got %h want 00000344", mem_addr); end
    mem_ack = 1'b0;
    reset   = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %b want 0", mem_req); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_async_stall: got %b want 1", stall); end
    n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL rst_miss_count: got %0d want 0", miss_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    run_refill(32'h0000_0348, 1, "post_rst");
    addr = 32'h0000_0104; #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_cleared_old: got %b want 1", stall); end
`ifdef IMEM_RESPONDER_STATS_EN
    n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL post_rst_miss_count: got %0d want 1", miss_count); end
`else
    n_checks++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL post_rst_miss_count: got %0d want 0", miss_count); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cold_miss();
    test_same_line_hit();
    test_conflict();
    test_wait_states();
    test_flush();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
